// File: rtl/scr1_pipe_fpu_wb_pkg.sv
// Shared FPU writeback types: destination tag, result-queue entry and fflags bit positions.
package scr1_pipe_fpu_wb_pkg;

    localparam int unsigned SCR1_FPU_WB_FLEN = 64;

    localparam int unsigned SCR1_FFLAGS_NX = 0;
    localparam int unsigned SCR1_FFLAGS_UF = 1;
    localparam int unsigned SCR1_FFLAGS_OF = 2;
    localparam int unsigned SCR1_FFLAGS_DZ = 3;
    localparam int unsigned SCR1_FFLAGS_NV = 4;

    typedef struct packed {
        logic [4:0] rd;
        logic       rd_fp;
        logic       dst_f32;
        logic       w32;
    } type_scr1_fpu_wb_tag_s;

    typedef struct packed {
        type_scr1_fpu_wb_tag_s         tag;
        logic [SCR1_FPU_WB_FLEN-1:0]   data;
        logic [4:0]                    status;
    } type_scr1_fpu_wb_entry_s;

endpackage

// File: rtl/scr1_fpu_wb_fifo.sv
// Small result queue for the FPU writeback stage; entry type and depth are parameters.
module scr1_fpu_wb_fifo #(
    parameter int unsigned DEPTH   = 2,
    parameter type         entry_t = logic
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push_i,
    input  entry_t push_data_i,
    input  logic   pop_i,
    output entry_t head_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_en, pop_en;
    entry_t           mem_q [DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign pop_en  = pop_i & ~empty_o;
    assign push_en = push_i & (~full_o | pop_en);
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = push_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_en  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push_en & ~pop_en) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_en & ~push_en) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count gates every read of it.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/scr1_pipe_fpu_wb.sv
// FPU writeback and fflags commit stage: tags the in-flight op, formats and queues results,
// drives the FPRF/MPRF write ports. SCR1_FPU_NANBOX_EN selects NaN-boxing of F32 FPRF writes.
module scr1_pipe_fpu_wb
    import scr1_pipe_fpu_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned FLEN  = SCR1_FPU_WB_FLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exu2wb_issue_i,
    input  logic [4:0]      exu2wb_rd_addr_i,
    input  logic            exu2wb_rd_fp_i,
    input  logic            exu2wb_dst_f32_i,
    input  logic            exu2wb_w32_i,
    output logic            wb2exu_issue_rdy_o,
    input  logic            fpu2wb_valid_i,
    input  logic [FLEN-1:0] fpu2wb_result_i,
    input  logic [4:0]      fpu2wb_status_i,
    output logic            wb2fprf_wr_o,
    output logic [4:0]      wb2fprf_addr_o,
    output logic [FLEN-1:0] wb2fprf_data_o,
    input  logic            fprf2wb_gnt_i,
    output logic            wb2mprf_wr_o,
    output logic [4:0]      wb2mprf_addr_o,
    output logic [FLEN-1:0] wb2mprf_data_o,
    input  logic            mprf2wb_gnt_i,
    input  logic            csr2wb_fflags_we_i,
    input  logic [4:0]      csr2wb_fflags_i,
    output logic [4:0]      wb2csr_fflags_o,
    output logic            wb2exu_done_o,
    output logic            wb2exu_err_o
);

`ifdef SCR1_FPU_NANBOX_EN
    localparam logic [FLEN-33:0] F32_UPPER = '1;
`else
    localparam logic [FLEN-33:0] F32_UPPER = '0;
`endif

    type_scr1_fpu_wb_tag_s   tag_q, tag_d;
    logic                    pending_q, pending_d;
    logic [4:0]              fflags_q, fflags_d;
    type_scr1_fpu_wb_entry_s push_entry, head;
    logic [FLEN-1:0]         fmt_data;
    logic                    full, empty, pop;
    logic                    issue_ok, valid_ok;

    assign wb2exu_issue_rdy_o = ~pending_q & ~full;
    assign issue_ok           = exu2wb_issue_i & wb2exu_issue_rdy_o;
    assign valid_ok           = fpu2wb_valid_i & pending_q;
    assign wb2exu_err_o       = (exu2wb_issue_i & ~wb2exu_issue_rdy_o)
                              | (fpu2wb_valid_i & ~pending_q);

    always_comb begin
        fmt_data = fpu2wb_result_i;
        if (tag_q.rd_fp & tag_q.dst_f32) begin
            fmt_data = {F32_UPPER, fpu2wb_result_i[31:0]};
        end else if (~tag_q.rd_fp & tag_q.w32) begin
            fmt_data = {{(FLEN-32){fpu2wb_result_i[31]}}, fpu2wb_result_i[31:0]};
        end
        push_entry.tag    = tag_q;
        push_entry.data   = SCR1_FPU_WB_FLEN'(fmt_data);
        push_entry.status = fpu2wb_status_i;
    end

    scr1_fpu_wb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (type_scr1_fpu_wb_entry_s)
    ) i_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (valid_ok),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (full),
        .empty_o     (empty)
    );

    // Address/data are zeroed while idle so the port is quiet after reset.
    assign wb2fprf_wr_o   = ~empty & head.tag.rd_fp;
    assign wb2mprf_wr_o   = ~empty & ~head.tag.rd_fp;
    assign wb2fprf_addr_o = wb2fprf_wr_o ? head.tag.rd : '0;
    assign wb2mprf_addr_o = wb2mprf_wr_o ? head.tag.rd : '0;
    assign wb2fprf_data_o = wb2fprf_wr_o ? head.data[FLEN-1:0] : '0;
    assign wb2mprf_data_o = wb2mprf_wr_o ? head.data[FLEN-1:0] : '0;
    assign pop            = (wb2fprf_wr_o & fprf2wb_gnt_i) | (wb2mprf_wr_o & mprf2wb_gnt_i);
    assign wb2exu_done_o  = pop;
    assign wb2csr_fflags_o = fflags_q;

    always_comb begin
        tag_d     = tag_q;
        pending_d = pending_q;
        fflags_d  = fflags_q;
        if (issue_ok) begin
            tag_d.rd      = exu2wb_rd_addr_i;
            tag_d.rd_fp   = exu2wb_rd_fp_i;
            tag_d.dst_f32 = exu2wb_dst_f32_i;
            tag_d.w32     = exu2wb_w32_i;
            pending_d     = 1'b1;
        end else if (valid_ok) begin
            pending_d = 1'b0;
        end
        // A CSR write replaces the old flags but still absorbs a same-cycle commit.
        if (csr2wb_fflags_we_i) begin
            fflags_d = csr2wb_fflags_i | (pop ? head.status : 5'b0);
        end else if (pop) begin
            fflags_d = fflags_q | head.status;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q     <= '0;
            pending_q <= 1'b0;
            fflags_q  <= '0;
        end else begin
            tag_q     <= tag_d;
            pending_q <= pending_d;
            fflags_q  <= fflags_d;
        end
    end

endmodule
